maxpool2x2_stream: RTL and testbench
====================================

Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the pointwise conv unit.
- Consumes one feature-map channel as a row-major stream of N-bit fixed-point samples (post-ReLU conv outputs), one sample per valid cycle.
- Emits one pooled sample per 2x2 window, row-major, plus an end-of-frame pulse.
- Needs only a half-row line buffer; no full-frame storage.

Parameters:
- N, 16, sample bit width; two's-complement signed.
- INPUT_SIZE, 28, feature-map width and height in samples; must be even and >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous frame abort; returns counters to frame start.
- input_vld  input  1  input sample valid, active high.
- input_din  input  N  input sample.
- pool_dout  output  N  pooled sample.
- pool_dout_vld  output  1  pooled sample valid; one-cycle pulse per window.
- pool_dout_end  output  1  high with the last pooled sample of a frame.

Behaviour:
- Reset (rst_n low, async):
  - pool_dout, pool_dout_vld, pool_dout_end = 0.
  - col, row counters = 0; horizontal-max register = 0.
  - Line-buffer contents are don't-care.
- Counters:
  - col and row are each 0..INPUT_SIZE-1, width clog2(INPUT_SIZE).
  - Both advance only on cycles with input_vld=1.
  - col wraps to 0 after INPUT_SIZE-1 and increments row.
  - row wraps to 0 after the last sample of a frame.
  - Next frame starts immediately; no idle cycle is required.
- Input gaps: input_vld may drop for any number of cycles mid-row or mid-frame. State holds and no output is produced.
- Horizontal stage:
  - Even col: hreg <= input_din.
  - Odd col: hmax = signed max(hreg, input_din), evaluated combinationally.
- Vertical stage:
  - Line buffer has INPUT_SIZE/2 entries of N bits, indexed by col>>1.
  - Even row, odd col: lbuf[col>>1] <= hmax. No output.
  - Odd row, odd col: next cycle, pool_dout <= signed max(lbuf[col>>1], hmax) and pool_dout_vld <= 1.
- Latency: pool_dout_vld rises exactly 1 cycle after the cycle accepting the bottom-right sample of a window.
- Output timing:
  - pool_dout_vld is low on every other cycle.
  - pool_dout holds its last value when pool_dout_vld is low.
- pool_dout_end is asserted on the same cycle as pool_dout_vld for window (row INPUT_SIZE-1, col INPUT_SIZE-1); low otherwise.
- Frame output count is (INPUT_SIZE/2)^2: 196 at the default size.
- Comparison rules:
  - Signed compare of full N bits.
  - On ties, either operand may be selected (values are equal).
  - No saturation or width growth; output width equals input width.
- clr:
  - Next cycle: col=0, row=0, hreg=0, pool_dout_vld=0, pool_dout_end=0.
  - pool_dout holds its value.
  - If clr and input_vld are high together, clr wins and the sample is discarded.
  - An output already scheduled for the clr cycle's next edge is suppressed.
- Reset mid-frame: everything returns to reset values immediately. The first valid sample after reset release is treated as (row 0, col 0).
- Throughput: one input per cycle sustained; no backpressure; no stall port.

Test Plan:
- INPUT_SIZE=4, inputs 0..15 row-major, input_vld held high:
  - Outputs are 5, 7, 13, 15.
  - pool_dout_vld pulses 1 cycle after inputs 5, 7, 13 and 15 are accepted.
  - pool_dout_end is high only with 15; exactly 4 vld pulses.
- INPUT_SIZE=4, same data, input_vld toggling 1,0,1,0...: same 4 outputs and values; each pulse occurs 1 cycle after its triggering accepted sample; no extra pulses.
- INPUT_SIZE=4, negative values (all samples 16'hFFFF except 16'h8000 at positions 0, 5, 10, 15) -> all four outputs are 16'hFFFF (-1), confirming a signed compare.
- Two back-to-back 4x4 frames (0..15, then 15..0), no gap:
  - Frame 1 gives 5, 7, 13, 15.
  - Frame 2 gives 15, 13, 7, 5.
  - pool_dout_end pulses twice.
- Assert rst_n low after sample 6 of a frame, then release and send a full 0..15 frame: no output during or after reset until the window completes; outputs are 5, 7, 13, 15.
- Pulse clr coincident with sample 7 of a frame, then send 0..15: sample 7 is ignored, no output is generated for it, and the new frame yields 5, 7, 13, 15 with a single end pulse.

Source files
------------

// File: rtl/maxpool2x2_stream_if.sv
// maxpool2x2_stream_if: raw sample stream into the pooling stage and pooled stream out of it.
interface maxpool2x2_stream_if #(parameter int N = 16);
    logic         input_vld;
    logic [N-1:0] input_din;
    logic [N-1:0] pool_dout;
    logic         pool_dout_vld;
    logic         pool_dout_end;
    modport master (
        output input_vld, input_din,
        input  pool_dout, pool_dout_vld, pool_dout_end
    );
    modport slave (
        input  input_vld, input_din,
        output pool_dout, pool_dout_vld, pool_dout_end
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 stride-2 signed max pooling over a row-major feature map,
// using a half-row line buffer to hold the top-row horizontal maxima.
module maxpool2x2_stream #(
    parameter int N          = 16,
    parameter int INPUT_SIZE = 28
) (
    input logic                clk,
    input logic                rst_n,
    input logic                clr,
    maxpool2x2_stream_if.slave strm
);
    localparam int CW = $clog2(INPUT_SIZE);
    localparam int HW = INPUT_SIZE / 2;
    localparam int LW = (HW > 1) ? $clog2(HW) : 1;
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

    logic [CW-1:0]       col, row;
    logic [LW-1:0]       idx;
    logic signed [N-1:0] din, hreg, hmax, vmax, lbuf_q;
    logic signed [N-1:0] lbuf [HW];
    logic                acc, win, fire;

    assign din    = $signed(strm.input_din);
    assign acc    = strm.input_vld & ~clr;
    assign win    = acc & col[0];
    assign fire   = win & row[0];
    assign idx    = LW'(col >> 1);
    assign lbuf_q = lbuf[idx];
    assign hmax   = (din > hreg) ? din : hreg;
    assign vmax   = (lbuf_q > hmax) ? lbuf_q : hmax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            hreg <= '0;
        end else if (clr) begin
            col  <= '0;
            row  <= '0;
            hreg <= '0;
        end else if (strm.input_vld) begin
            col <= (col == LAST) ? '0 : col + 1'b1;
            if (col == LAST)
                row <= (row == LAST) ? '0 : row + 1'b1;
            if (!col[0])
                hreg <= din;
        end
    end

    // Line buffer needs no reset: every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (win && !row[0])
            lbuf[idx] <= hmax;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strm.pool_dout     <= '0;
            strm.pool_dout_vld <= 1'b0;
            strm.pool_dout_end <= 1'b0;
        end else begin
            strm.pool_dout_vld <= fire;
            strm.pool_dout_end <= fire & (row == LAST) & (col == LAST);
            if (fire)
                strm.pool_dout <= vmax;
        end
    end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: directed table-driven check of the 4x4 pooling stage, plus
// hand-written reset and clr sequences.
module tb_maxpool2x2_stream;
    typedef struct {
        logic        vld;
        logic [15:0] din;
        logic        clr;
        logic        ev;
        logic        ee;
        logic [15:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] last_out = '0;
    vec_t        tbl[$];

    maxpool2x2_stream_if #(.N(16)) strm();

    maxpool2x2_stream #(.N(16), .INPUT_SIZE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .strm  (strm)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string name, logic ev, logic ee);
        chk({name, " vld"}, {15'b0, strm.pool_dout_vld}, {15'b0, ev});
        chk({name, " end"}, {15'b0, strm.pool_dout_end}, {15'b0, ee});
        chk({name, " dout"}, strm.pool_dout, last_out);
    endtask

    function automatic vec_t mk(logic v, logic [15:0] d, logic c, logic ev, logic ee, logic [15:0] ed);
        vec_t r;
        r.vld = v; r.din = d; r.clr = c; r.ev = ev; r.ee = ee; r.ed = ed;
        return r;
    endfunction

    // Bottom-right positions of the four windows in a 4x4 row-major frame.
    function automatic logic br(int i);
        return (i == 5) || (i == 7) || (i == 13) || (i == 15);
    endfunction

    task automatic apply(string name, vec_t v);
        @(negedge clk);
        strm.input_vld = v.vld;
        strm.input_din = v.din;
        clr = v.clr;
        @(posedge clk);
        #1;
        if (v.ev) last_out = v.ed;
        check_outs(name, v.ev, v.ee);
    endtask

    task automatic run_tbl(string tag);
        foreach (tbl[i]) apply($sformatf("%s[%0d]", tag, i), tbl[i]);
        tbl.delete();
    endtask

    task automatic push_up_frame();
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1'b1, 16'(i), 1'b0, br(i), i == 15, 16'(i)));
    endtask

    initial begin
        strm.input_vld = 1'b0;
        strm.input_din = '0;
        #12;
        check_outs("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        push_up_frame();
        run_tbl("ramp");

        for (int i = 0; i < 16; i++) begin
            tbl.push_back(mk(1'b1, 16'(i), 1'b0, br(i), i == 15, 16'(i)));
            tbl.push_back(mk(1'b0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0));
        end
        run_tbl("gaps");

        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1'b1, (i == 0 || i == 5 || i == 10 || i == 15) ? 16'h8000 : 16'hFFFF,
                             1'b0, br(i), i == 15, 16'hFFFF));
        run_tbl("neg");

        push_up_frame();
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1'b1, 16'(15 - i), 1'b0, br(i), i == 15, 16'(20 - i)));
        run_tbl("b2b");

        // Reset mid-frame after samples 0..6.
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1'b1, 16'(i), 1'b0, i == 5, 1'b0, 16'd5));
        run_tbl("prerst");
        @(negedge clk);
        rst_n = 1'b0;
        strm.input_vld = 1'b1;
        strm.input_din = 16'd9;
        #1;
        last_out = '0;
        check_outs("rst_async", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst_hold", 1'b0, 1'b0);
        @(negedge clk);
        strm.input_vld = 1'b0;
        rst_n = 1'b1;
        push_up_frame();
        run_tbl("postrst");

        // clr coincident with sample 7, which would otherwise complete window 1.
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1'b1, 16'(i), 1'b0, i == 5, 1'b0, 16'd5));
        tbl.push_back(mk(1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0));
        run_tbl("clr");
        push_up_frame();
        run_tbl("postclr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
